traffic_phase_sequencer: RTL and testbench
==========================================

# traffic_phase_sequencer

Six-phase, two-road traffic-light sequencer. It owns the phase-duration counter and drives it through load, decrement and expiry, the way a controller drives the saturating counter. Per-phase durations are software-loadable through a one-hot write port. One-hot light outputs go to the lamp drivers; `remaining` and `phaseDone` go to the display and status logic.

## Interface
- `COUNT_SIZE`, 5, width of duration registers and phase counter
- `GREEN_INIT`, 20, reset value of green duration (cycles)
- `YELLOW_INIT`, 4, reset value of yellow duration
- `ALLRED_INIT`, 2, reset value of all-red duration
- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  reset, asynchronous and active-high
- `enable`  in  1  1 = sequencer runs; 0 = freeze all state
- `cfgSel`  in  3  one-hot duration write select: [2] green, [1] yellow, [0] all-red; 000 = no write
- `cfgIn`  in  COUNT_SIZE  duration value to write
- `nsLight`  out  3  north-south lamps, one-hot {red, yellow, green}
- `ewLight`  out  3  east-west lamps, one-hot {red, yellow, green}
- `phase`  out  3  current state encoding (see Operation)
- `remaining`  out  COUNT_SIZE  cycles left in the phase minus one
- `phaseDone`  out  1  high during the last cycle of a phase

## Operation
- **States and encodings:** ALLRED_A=0, NS_GREEN=1, NS_YELLOW=2, ALLRED_B=3, EW_GREEN=4, EW_YELLOW=5.
- **Transition order:** 0→1→2→3→4→5→0, fixed.
- **Illegal state encodings** 6 and 7 go to ALLRED_A on the next edge, with `remaining` loaded from all-red.
- **Lights (combinational decode of the state register):**
  - NS_GREEN: ns=001, ew=100.
  - NS_YELLOW: ns=010, ew=100.
  - EW_GREEN: ns=100, ew=001.
  - EW_YELLOW: ns=100, ew=010.
  - ALLRED_A, ALLRED_B, illegal: both 100.
- **Both roads are never non-red in the same cycle.**
- **Duration registers** G, Y, R are COUNT_SIZE bits wide.
  - On reset they take GREEN_INIT, YELLOW_INIT and ALLRED_INIT.
  - When `cfgSel[i]` is set, the selected register takes `cfgIn` at the edge.
  - Writes are independent of `enable`.
  - Non-one-hot `cfgSel`: every selected register is written.
- **Effective duration** D = max(register, 1). A value of 0 behaves as 1.
- **Phase counter, on each rising edge with `enable` = 1:**
  - If `remaining` > 0: `remaining` ← `remaining` − 1.
  - If `remaining` = 0: state ← next state, and `remaining` ← D(next) − 1.
  - The counter saturates at 0 and never wraps.
- **`enable` = 0:** state and `remaining` hold; `phaseDone` = 0.
- **`phaseDone`** = `enable` & (`remaining` == 0). It is combinational.
- **Phase length:** a phase lasts exactly D enabled cycles.
- **Full-cycle length** with defaults: 2+20+4+2+20+4 = 52 cycles.
- **Width rule:** D − 1 is computed in COUNT_SIZE bits. D ≤ 2^COUNT_SIZE − 1, so no overflow.

## Timing
- **Reset values:**
  - phase = 0 and `remaining` = max(ALLRED_INIT, 1) − 1.
  - nsLight = ewLight = 100 and `phaseDone` = (`enable` & `remaining` == 0).
  - G, Y, R = their INIT values.
- **`rst` assertion:** takes effect immediately, with no clock edge. This holds mid-phase and mid-write; a write in the same cycle as `rst` is lost.
- **First edge after `rst` deasserts:** normal operation.
- **Latency:**
  - Light outputs change in the same cycle the state register updates.
  - A config write is visible in the register one edge later.
- **Write coinciding with a load of the same register:** the load uses the OLD register value. The new value applies at the next entry into that phase.
- **Write to the running phase's register:** does not alter `remaining`.

## Test plan
- **Reset and defaults:** assert `rst` mid-NS_GREEN without a clock edge.
  - Required: immediate phase=0, ns=ew=100, `remaining`=1.
  - Release `rst` with `enable`=1. Required: phase=1 after exactly 2 edges with `remaining`=19.
- **Full cycle:** `enable`=1 for 52 edges after reset.
  - Required: phase sequence 0(2),1(20),2(4),3(2),4(20),5(4) cycles, then back to phase 0.
  - Required: `phaseDone` pulses exactly 6 times, and no cycle has both roads non-red.
- **Freeze:** deassert `enable` for 7 cycles at NS_GREEN with `remaining`=10.
  - Required: phase, `remaining` and lights unchanged, `phaseDone`=0.
  - Required: on re-enable, 11 further edges to reach NS_YELLOW.
- **Config write:** `cfgSel`=100, `cfgIn`=5 during NS_GREEN.
  - Required: the current green still completes its 20 cycles.
  - Required: EW_GREEN lasts 5 cycles.
  - Write `cfgSel`=010, `cfgIn`=0. Required: yellow lasts 1 cycle.
- **Write/load collision:** write Y=7 on the same edge that enters NS_YELLOW.
  - Required: this yellow lasts 4 cycles, and EW_YELLOW lasts 7 cycles.
- **Saturation/maximum:** G=31 with COUNT_SIZE=5.
  - Required: green lasts 31 cycles, `remaining` starts at 30 and never wraps below 0.

Source files
------------

// File: rtl/traffic_phase_sequencer.sv
// Six-phase, two-road traffic-light sequencer with software-loadable phase durations.
// Owns the phase-duration down-counter: load on phase entry, decrement, expire.
module traffic_phase_sequencer #(
  parameter int unsigned COUNT_SIZE  = 5,
  parameter int unsigned GREEN_INIT  = 20,
  parameter int unsigned YELLOW_INIT = 4,
  parameter int unsigned ALLRED_INIT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [2:0]            cfgSel,
  input  logic [COUNT_SIZE-1:0] cfgIn,
  output logic [2:0]            nsLight,
  output logic [2:0]            ewLight,
  output logic [2:0]            phase,
  output logic [COUNT_SIZE-1:0] remaining,
  output logic                  phaseDone
);

  typedef enum logic [2:0] {
    ALLRED_A  = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    ALLRED_B  = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5
  } state_t;

  localparam logic [COUNT_SIZE-1:0] RST_REM =
    (ALLRED_INIT > 1) ? COUNT_SIZE'(ALLRED_INIT - 1) : '0;

  state_t                state, state_nx, succ;
  logic [COUNT_SIZE-1:0] g_dur, y_dur, r_dur;
  logic [COUNT_SIZE-1:0] rem_q, rem_nx, load_dur;
  logic                  illegal;

  // Effective duration minus one: a programmed 0 behaves as 1.
  function automatic logic [COUNT_SIZE-1:0] dur_m1(input logic [COUNT_SIZE-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ALLRED_A;
      rem_q <= RST_REM;
    end else begin
      state <= state_nx;
      rem_q <= rem_nx;
    end
  end

  // Loads below read the pre-write register value, so a write landing on the
  // entry edge of its own phase only takes effect at the next entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_dur <= COUNT_SIZE'(GREEN_INIT);
      y_dur <= COUNT_SIZE'(YELLOW_INIT);
      r_dur <= COUNT_SIZE'(ALLRED_INIT);
    end else begin
      if (cfgSel[2]) g_dur <= cfgIn;
      if (cfgSel[1]) y_dur <= cfgIn;
      if (cfgSel[0]) r_dur <= cfgIn;
    end
  end

  always_comb begin
    succ     = ALLRED_A;
    illegal  = 1'b0;
    nsLight  = 3'b100;
    ewLight  = 3'b100;
    case (state)
      ALLRED_A:  succ = NS_GREEN;
      NS_GREEN:  begin succ = NS_YELLOW; nsLight = 3'b001; end
      NS_YELLOW: begin succ = ALLRED_B;  nsLight = 3'b010; end
      ALLRED_B:  succ = EW_GREEN;
      EW_GREEN:  begin succ = EW_YELLOW; ewLight = 3'b001; end
      EW_YELLOW: begin succ = ALLRED_A;  ewLight = 3'b010; end
      default:   illegal = 1'b1;
    endcase

    case (succ)
      NS_GREEN, EW_GREEN:   load_dur = g_dur;
      NS_YELLOW, EW_YELLOW: load_dur = y_dur;
      default:              load_dur = r_dur;
    endcase

    state_nx = state;
    rem_nx   = rem_q;
    if (illegal) begin
      state_nx = ALLRED_A;
      rem_nx   = dur_m1(r_dur);
    end else if (enable) begin
      if (rem_q != '0) begin
        rem_nx = rem_q - 1'b1;
      end else begin
        state_nx = succ;
        rem_nx   = dur_m1(load_dur);
      end
    end
  end

  assign phase     = state;
  assign remaining = rem_q;
  assign phaseDone = enable & (rem_q == '0);

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Scoreboard bench for traffic_phase_sequencer: directed phase-length checks plus
// randomized enable/config traffic against a cycles-left reference model.
module tb_traffic_phase_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [2:0] cfgSel;
  logic [4:0] cfgIn;
  logic [2:0] nsLight, ewLight, phase;
  logic [4:0] remaining;
  logic       phaseDone;

  traffic_phase_sequencer #(
    .COUNT_SIZE(5), .GREEN_INIT(20), .YELLOW_INIT(4), .ALLRED_INIT(2)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .cfgSel(cfgSel), .cfgIn(cfgIn),
    .nsLight(nsLight), .ewLight(ewLight), .phase(phase),
    .remaining(remaining), .phaseDone(phaseDone)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       ph;
    int       rem;
    logic [2:0] ns;
    logic [2:0] ew;
    logic     pd;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // Reference model: phase index plus number of cycles still left in it.
  int m_ph, m_left, m_g, m_y, m_r;

  function automatic int eff(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic int dur_of(input int p);
    if (p == 1 || p == 4) return eff(m_g);
    if (p == 2 || p == 5) return eff(m_y);
    return eff(m_r);
  endfunction

  function automatic logic [2:0] ns_of(input int p);
    return (p == 1) ? 3'b001 : (p == 2) ? 3'b010 : 3'b100;
  endfunction

  function automatic logic [2:0] ew_of(input int p);
    return (p == 4) ? 3'b001 : (p == 5) ? 3'b010 : 3'b100;
  endfunction

  task automatic model_reset();
    m_g = 20; m_y = 4; m_r = 2;
    m_ph = 0;
    m_left = eff(m_r);
    q.delete();
  endtask

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic step(input logic en, input logic [2:0] sel, input logic [4:0] din);
    exp_t e;
    @(negedge clk);
    enable = en; cfgSel = sel; cfgIn = din;
    @(posedge clk);
    if (en) begin
      if (m_left > 1) m_left--;
      else begin
        m_ph   = (m_ph + 1) % 6;
        m_left = dur_of(m_ph);
      end
    end
    if (sel[2]) m_g = int'(din);
    if (sel[1]) m_y = int'(din);
    if (sel[0]) m_r = int'(din);
    e.ph = m_ph; e.rem = m_left - 1;
    e.ns = ns_of(m_ph); e.ew = ew_of(m_ph);
    e.pd = en && (m_left == 1);
    q.push_back(e);
    #1;
  endtask

  // Counts enabled cycles until the DUT leaves the phase it is in now.
  task automatic hold_phase(input logic [2:0] sel, input logic [4:0] din, output int n);
    int start;
    start = int'(phase);
    step(1'b1, sel, din);
    n = 1;
    while (int'(phase) == start && n < 100) begin
      step(1'b1, 3'b000, 5'd0);
      n++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    enable = 1'b0; cfgSel = 3'b000;
    #2 rst = 1'b1;
    #1;
    chk("rst_phase", int'(phase), 0);
    chk("rst_remaining", int'(remaining), 1);
    chk("rst_ns", int'(nsLight), 4);
    chk("rst_ew", int'(ewLight), 4);
    chk("rst_done", int'(phaseDone), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: compares every scoreboard entry and the mutual-exclusion rule.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      while (q.size() > 0) begin
        e = q.pop_front();
        total++;
        if (int'(phase) != e.ph || int'(remaining) != e.rem || nsLight != e.ns ||
            ewLight != e.ew || phaseDone != e.pd) begin
          bad++;
          $display("FAIL sb: got ph=%0d rem=%0d ns=%b ew=%b done=%b expected ph=%0d rem=%0d ns=%b ew=%b done=%b at %0t",
                   phase, remaining, nsLight, ewLight, phaseDone,
                   e.ph, e.rem, e.ns, e.ew, e.pd, $time);
        end
      end
      total++;
      if (nsLight != 3'b100 && ewLight != 3'b100) begin
        bad++;
        $display("FAIL both_green: got ns=%b ew=%b expected one road red at %0t", nsLight, ewLight, $time);
      end
    end
  end

  initial begin
    int n, pd;
    logic       en;
    logic [2:0] sel;
    logic [4:0] din;
    rst = 1'b1; enable = 1'b0; cfgSel = 3'b000; cfgIn = 5'd0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("init_phase", int'(phase), 0);
    chk("init_remaining", int'(remaining), 1);
    chk("init_ns", int'(nsLight), 4);
    chk("init_ew", int'(ewLight), 4);
    chk("init_done", int'(phaseDone), 0);
    rst = 1'b0;

    // Full default cycle: 52 edges back to ALLRED_A, six done pulses.
    pd = 0;
    for (int i = 0; i < 52; i++) begin
      step(1'b1, 3'b000, 5'd0);
      if (i == 1) begin
        chk("first_green_phase", int'(phase), 1);
        chk("first_green_rem", int'(remaining), 19);
      end
      if (phaseDone) pd++;
    end
    chk("cycle_done_pulses", pd, 6);
    chk("cycle_end_phase", int'(phase), 0);
    chk("cycle_end_rem", int'(remaining), 1);

    // Asynchronous reset in the middle of NS_GREEN.
    repeat (10) step(1'b1, 3'b000, 5'd0);
    do_reset();
    step(1'b1, 3'b000, 5'd0);
    step(1'b1, 3'b000, 5'd0);
    chk("post_rst_phase", int'(phase), 1);
    chk("post_rst_rem", int'(remaining), 19);

    // Freeze at remaining=10.
    repeat (9) step(1'b1, 3'b000, 5'd0);
    chk("pre_freeze_rem", int'(remaining), 10);
    repeat (7) step(1'b0, 3'b000, 5'd0);
    chk("freeze_phase", int'(phase), 1);
    chk("freeze_rem", int'(remaining), 10);
    chk("freeze_done", int'(phaseDone), 0);
    hold_phase(3'b000, 5'd0, n);
    chk("unfreeze_edges", n, 11);

    // Config writes: running green unaffected, new values at next entry.
    do_reset();
    step(1'b1, 3'b000, 5'd0);
    step(1'b1, 3'b000, 5'd0);
    hold_phase(3'b100, 5'd5, n);  chk("ns_green_len_during_write", n, 20);
    hold_phase(3'b000, 5'd0, n);  chk("ns_yellow_len", n, 4);
    hold_phase(3'b000, 5'd0, n);  chk("allred_b_len", n, 2);
    hold_phase(3'b000, 5'd0, n);  chk("ew_green_len_g5", n, 5);
    hold_phase(3'b010, 5'd0, n);  chk("ew_yellow_len_during_write", n, 4);
    hold_phase(3'b000, 5'd0, n);  chk("allred_a_len", n, 2);
    hold_phase(3'b000, 5'd0, n);  chk("ns_green_len_g5", n, 5);
    hold_phase(3'b000, 5'd0, n);  chk("ns_yellow_len_y0", n, 1);

    // Write/load collision on the NS_YELLOW entry edge.
    do_reset();
    step(1'b1, 3'b000, 5'd0);
    step(1'b1, 3'b000, 5'd0);
    repeat (19) step(1'b1, 3'b000, 5'd0);
    chk("pre_collision_rem", int'(remaining), 0);
    step(1'b1, 3'b010, 5'd7);
    chk("collision_phase", int'(phase), 2);
    hold_phase(3'b000, 5'd0, n);  chk("collision_yellow_len", n, 4);
    hold_phase(3'b000, 5'd0, n);  chk("collision_allred_len", n, 2);
    hold_phase(3'b000, 5'd0, n);  chk("collision_ew_green_len", n, 20);
    hold_phase(3'b000, 5'd0, n);  chk("collision_ew_yellow_len", n, 7);

    // Maximum duration.
    do_reset();
    step(1'b0, 3'b100, 5'd31);
    step(1'b1, 3'b000, 5'd0);
    step(1'b1, 3'b000, 5'd0);
    chk("max_green_phase", int'(phase), 1);
    chk("max_green_rem", int'(remaining), 30);
    hold_phase(3'b000, 5'd0, n);  chk("max_green_len", n, 31);

    // Randomized enable, config traffic and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      en  = ($urandom % 8) != 0;
      sel = (($urandom % 10) == 0) ? 3'($urandom % 8) : 3'b000;
      din = (($urandom % 4) == 0) ? 5'($urandom % 32) : 5'($urandom_range(0, 6));
      if (($urandom % 600) == 0) do_reset();
      else step(en, sel, din);
    end
    step(1'b0, 3'b000, 5'd0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
